dkong_dac_filter: RTL

DKONG_DAC_FILTER -- requirements
Module: dkong_dac_filter

---
 rtl/dkong_dac_filter_if.sv | 19 +
 rtl/dkong_dac_filter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dkong_dac_filter_if.sv
// DAC filter sample bus: CPU-side DAC code and controls in, filtered sample strobe out.
// master = stimulus/CPU side, slave = dkong_dac_filter.
interface dkong_dac_filter_if;
  logic        [7:0]  I_DAC_DAT;
  logic               I_DECAY_EN;
  logic               I_MUTE;
  logic signed [15:0] O_SAMPLE;
  logic               O_VALID;

  modport master (
    output I_DAC_DAT, I_DECAY_EN, I_MUTE,
    input  O_SAMPLE, O_VALID
  );

  modport slave (
    input  I_DAC_DAT, I_DECAY_EN, I_MUTE,
    output O_SAMPLE, O_VALID
  );
endinterface

// File: rtl/dkong_dac_filter.sv
// Donkey Kong 8035 DAC post-processing: decimate, apply decaying envelope, optional one-pole LPF.
// Define DKONG_DAC_LPF_EN to enable the low-pass stage; otherwise FILT passes X straight through.
module dkong_dac_filter #(
  parameter int DIV         = 500,
  parameter int DECAY_SHIFT = 9,
  parameter int LPF_SHIFT   = 3
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  dkong_dac_filter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FILT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  // One decay step; the decrement is at least 1 so the envelope always reaches 0 and stops there.
  function automatic logic [15:0] env_step(input logic [15:0] env);
    logic [15:0] dec;
    dec = env >> DECAY_SHIFT;
    dec = (dec == 16'd0) ? 16'd1 : dec;
    return (env > dec) ? (env - dec) : 16'd0;
  endfunction

  state_t             state_r, state_next_s;
  logic        [15:0] cnt_r;
  logic        [7:0]  dreg_r;
  logic        [15:0] env_r;
  logic signed [15:0] x_r, y_r, sample_r;
  logic               valid_r;
  logic               tick_s;
  logic signed [8:0]  dac_centered_s;
  logic signed [17:0] prod_s;
  logic signed [15:0] y_next_s;
`ifdef DKONG_DAC_LPF_EN
  logic signed [16:0] diff_s;
  logic signed [16:0] step_s;
`endif

  assign tick_s = (cnt_r == CNT_LAST);

  // Sample-rate divider.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      cnt_r <= 16'd0;
    end else if (tick_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next state: one pass IDLE->MUL->FILT->OUT per tick.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (tick_s) begin
          state_next_s = S_MUL;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_MUL:   state_next_s = S_FILT;
      S_FILT:  state_next_s = S_OUT;
      S_OUT:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Centred DAC code times envelope high byte, and the filter update.
  always_comb begin
    dac_centered_s = $signed({1'b0, dreg_r}) - 9'sd128;
    prod_s         = dac_centered_s * $signed({1'b0, env_r[15:8]});
`ifdef DKONG_DAC_LPF_EN
    diff_s   = {x_r[15], x_r} - {y_r[15], y_r};
    step_s   = diff_s >>> LPF_SHIFT;
    y_next_s = y_r + 16'(step_s);
`else
    y_next_s = x_r;
`endif
  end

  // Datapath registers; reset mid-sequence discards the sample in flight.
  always_ff @(posedge I_CLK) begin
    if (!I_RST) begin
      dreg_r   <= 8'h80;
      env_r    <= 16'hFFFF;
      x_r      <= 16'sd0;
      y_r      <= 16'sd0;
      sample_r <= 16'sd0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (tick_s) begin
        dreg_r <= bus.I_DAC_DAT;
        env_r  <= bus.I_DECAY_EN ? env_step(env_r) : 16'hFFFF;
      end
      case (state_r)
        S_MUL:  x_r <= bus.I_MUTE ? 16'sd0 : 16'(prod_s);
        S_FILT: y_r <= y_next_s;
        S_OUT: begin
          sample_r <= y_r;
          valid_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.O_SAMPLE = sample_r;
  assign bus.O_VALID  = valid_r;

endmodule
